platform_scroll_ctrl: RTL and testbench
=======================================

// Module: platform_scroll_ctrl
// PURPOSE
// - Frame-rate scheduler for the platform field of the doodle game. Owns the position table of
//   NUM_PLAT platforms and sequences a per-frame update: compute the scroll amount from the doodle
//   height, shift every platform down, and respawn wrapped platforms at the top at an LFSR x.
// - Sits between the doodle state machine, which supplies doodle_y and consumes scroll_amt, and
//   the VGA painter, which reads platform boxes through rd_idx/rd_x/rd_y.
// PARAMETERS
// - NUM_PLAT     8       number of platforms, 2..16
// - V_RES        480     visible lines; y wraps modulo V_RES
// - SCROLL_LINE  200     doodle_y below this (higher on screen) triggers a scroll
// - MAX_STEP     8       scroll_amt saturation per frame
// - LFSR_SEED    16'hACE1  nonzero LFSR reset value
// PORTS
// - Clk         in   1   clock
// - reset       in   1   asynchronous, active-high
// - frame_tick  in   1   1-cycle pulse per frame (end of vsync)
// - doodle_y    in   10  current doodle top y
// - rd_idx      in   4   platform read index
// - rd_x        out  10  x of platform rd_idx; combinational; 0 if rd_idx>=NUM_PLAT
// - rd_y        out  10  y of platform rd_idx; combinational; 0 if rd_idx>=NUM_PLAT
// - scroll_amt  out  10  scroll applied this frame; held until the next CALC
// - busy        out  1   high in CALC/SCAN/DONE
// - done        out  1   1-cycle pulse at end of update
// - overrun     out  1   sticky: frame_tick arrived while busy
// - score       out  16  cumulative scroll (see CONFIGURATION)
// BEHAVIOUR
// - Clock and reset: clock Clk; reset reset, asynchronous, active-high.
// - Reset values: platform i y = i*(V_RES/NUM_PLAT), x = (i*73) mod 512; lfsr = LFSR_SEED;
//   scroll_amt = 0, busy = 0, done = 0, overrun = 0, score = 0; state IDLE.
// - Reset mid-update aborts immediately. No done pulse is produced and the table returns to
//   its reset values.
// - FSM IDLE->CALC->SCAN->DONE->IDLE. Cycle 0 is the frame_tick cycle.
//   - IDLE: on frame_tick, go to CALC.
//   - CALC (cycle 1): if doodle_y < SCROLL_LINE, amt = min(SCROLL_LINE-doodle_y, MAX_STEP);
//     otherwise amt = 0. Register amt into scroll_amt. If amt == 0, go to DONE; otherwise
//     idx = 0 and go to SCAN.
//   - SCAN: one platform per cycle, idx = 0..NUM_PLAT-1 (cycles 2..NUM_PLAT+1).
//     - Compute sum = y + amt in 11 bits.
//     - If sum >= V_RES: y = sum - V_RES; advance the LFSR one step; x = {1'b0, lfsr_next[8:0]}.
//     - Otherwise y = sum and x is unchanged.
//   - DONE: done = 1 for one cycle, then IDLE. done is at cycle NUM_PLAT+2, or cycle 2 if amt == 0.
// - LFSR: 16-bit Galois, shift right, XOR 16'hB400 when the shifted-out bit is 1. It advances
//   only on respawn.
// - frame_tick while busy is ignored and sets overrun, which stays set until reset.
// - Table is coherent only while busy == 0; the painter must sample outside busy.
// - Multiple respawns in one frame each advance the LFSR once, in idx order.
// CONFIGURATION
// - PLAT_CTRL_SCORE_EN defined: score += scroll_amt in the DONE state, saturating at 16'hFFFF.
// - PLAT_CTRL_SCORE_EN undefined: no score register; score is tied to 16'h0000.
// TESTING
// - Reset (defaults) -> rd_idx=3 gives rd_y=180, rd_x=219; busy=0, scroll_amt=0, done=0.
// - frame_tick, doodle_y=300 -> scroll_amt=0, done pulses at cycle 2, all y unchanged.
// - frame_tick, doodle_y=150 -> scroll_amt=8 (saturated); busy cycles 1-10, done at cycle 10;
//   platform0 y=8, platform7 y=428.
// - 8 frames with doodle_y=150 -> on frame 8 platform7: 484 wraps to y=4, LFSR 16'hACE1 to
//   16'hE270, x=112; other platforms' x unchanged.
// - frame_tick at cycle 4 of an update -> ignored; done still at cycle 10; overrun=1 until reset.
// - With PLAT_CTRL_SCORE_EN, after the test-3 frame -> score=8; without the macro, score=0.

Source files
------------

// File: rtl/platform_scroll_ctrl.sv
// Per-frame platform scroll scheduler for the doodle game.
// Holds the NUM_PLAT platform position table. On each frame_tick it
// computes the scroll amount from doodle_y, shifts every platform down
// by one entry per cycle, and respawns wrapped platforms at an LFSR x.
// Optional feature macro: PLAT_CTRL_SCORE_EN adds a saturating
// cumulative score; without it the score output is tied to zero.
module platform_scroll_ctrl #(
  parameter int unsigned NUM_PLAT    = 8,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned SCROLL_LINE = 200,
  parameter int unsigned MAX_STEP    = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  doodle_y,
  input  logic [3:0]  rd_idx,
  output logic [9:0]  rd_x,
  output logic [9:0]  rd_y,
  output logic [9:0]  scroll_amt,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] score
);

  localparam logic [10:0] VRES11   = 11'(V_RES);
  localparam logic [9:0]  SCROLL10 = 10'(SCROLL_LINE);
  localparam logic [9:0]  STEP10   = 10'(MAX_STEP);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_PLAT - 1);

  typedef enum logic [1:0] {IDLE, CALC, SCAN, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  plat_x_q [NUM_PLAT];
  logic [9:0]  plat_x_d [NUM_PLAT];
  logic [9:0]  plat_y_q [NUM_PLAT];
  logic [9:0]  plat_y_d [NUM_PLAT];
  logic [15:0] lfsr_q, lfsr_d, lfsr_next;
  logic [9:0]  scroll_amt_q, scroll_amt_d;
  logic [3:0]  idx_q, idx_d;
  logic        overrun_q, overrun_d;
  logic [9:0]  amt_calc, diff, cur_y;
  logic [10:0] scan_sum;

  // State register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (frame_tick) state_d = CALC;
      CALC: state_d = (amt_calc == '0) ? DONE : SCAN;
      SCAN: if (idx_q == LAST_IDX) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Scroll amount: distance above the scroll line, saturated to MAX_STEP
  always_comb begin
    diff     = SCROLL10 - doodle_y;
    amt_calc = '0;
    if (doodle_y < SCROLL10) amt_calc = (diff < STEP10) ? diff : STEP10;
  end

  // Combinational read port for the painter
  always_comb begin
    rd_x = '0;
    rd_y = '0;
    for (int unsigned i = 0; i < NUM_PLAT; i++) begin
      if (rd_idx == 4'(i)) begin
        rd_x = plat_x_q[i];
        rd_y = plat_y_q[i];
      end
    end
  end

  // Datapath next values: table scan, LFSR respawn, overrun flag
  always_comb begin
    scroll_amt_d = scroll_amt_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    overrun_d    = overrun_q;
    plat_x_d     = plat_x_q;
    plat_y_d     = plat_y_q;
    lfsr_next    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    cur_y        = '0;
    for (int unsigned i = 0; i < NUM_PLAT; i++) begin
      if (idx_q == 4'(i)) cur_y = plat_y_q[i];
    end
    scan_sum = {1'b0, cur_y} + {1'b0, scroll_amt_q};

    if (frame_tick && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      CALC: begin
        scroll_amt_d = amt_calc;
        idx_d        = '0;
      end
      SCAN: begin
        idx_d = idx_q + 4'd1;
        for (int unsigned i = 0; i < NUM_PLAT; i++) begin
          if (idx_q == 4'(i)) begin
            if (scan_sum >= VRES11) begin
              plat_y_d[i] = 10'(scan_sum - VRES11);
              lfsr_d      = lfsr_next;
              plat_x_d[i] = {1'b0, lfsr_next[8:0]};
            end else begin
              plat_y_d[i] = scan_sum[9:0];
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset restores the initial platform layout
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PLAT; i++) begin
        plat_y_q[i] <= 10'(i * (V_RES / NUM_PLAT));
        plat_x_q[i] <= 10'((i * 73) % 512);
      end
      lfsr_q       <= LFSR_SEED;
      scroll_amt_q <= '0;
      idx_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      plat_x_q     <= plat_x_d;
      plat_y_q     <= plat_y_d;
      lfsr_q       <= lfsr_d;
      scroll_amt_q <= scroll_amt_d;
      idx_q        <= idx_d;
      overrun_q    <= overrun_d;
    end
  end

  assign scroll_amt = scroll_amt_q;
  assign overrun    = overrun_q;

`ifdef PLAT_CTRL_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  // Saturating score accumulation, once per update in DONE
  always_comb begin
    score_sum = {1'b0, score_q} + {7'd0, scroll_amt_q};
    score_d   = score_q;
    if (state_q == DONE) score_d = score_sum[16] ? '1 : score_sum[15:0];
  end

  // Score register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_platform_scroll_ctrl.sv
// Self-checking bench for platform_scroll_ctrl with a frame-level reference model.
module tb_platform_scroll_ctrl;

  localparam int NP = 8;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [9:0]  doodle_y = '0;
  logic [3:0]  rd_idx = '0;
  logic [9:0]  rd_x, rd_y, scroll_amt;
  logic        busy, done, overrun;
  logic [15:0] score;

  platform_scroll_ctrl #(.NUM_PLAT(NP)) dut (
    .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .doodle_y(doodle_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .scroll_amt(scroll_amt),
    .busy(busy), .done(done), .overrun(overrun), .score(score)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_x[NP];
  int m_y[NP];
  int m_lfsr, m_amt, m_score, m_overrun;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lfsr_step(input int l);
    int n;
    n = l / 2;
    if (l % 2 == 1) n = n ^ 'hB400;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_y[i] = i * (480 / NP);
      m_x[i] = (i * 73) % 512;
    end
    m_lfsr = 'hACE1; m_amt = 0; m_score = 0; m_overrun = 0;
  endtask

  task automatic model_frame(input int dy);
    int s;
    m_amt = 0;
    if (dy < 200) m_amt = (200 - dy < 8) ? 200 - dy : 8;
    for (int i = 0; i < NP; i++) begin
      s = m_y[i] + m_amt;
      if (s >= 480) begin
        m_y[i] = s - 480;
        m_lfsr = lfsr_step(m_lfsr);
        m_x[i] = m_lfsr % 512;
      end else m_y[i] = s;
    end
`ifdef PLAT_CTRL_SCORE_EN
    m_score = (m_score + m_amt > 65535) ? 65535 : m_score + m_amt;
`endif
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      check($sformatf("%s_y%0d", tag, i), 32'(rd_y), (i < NP) ? 32'(m_y[i]) : 32'd0);
      check($sformatf("%s_x%0d", tag, i), 32'(rd_x), (i < NP) ? 32'(m_x[i]) : 32'd0);
    end
  endtask

  // One frame update; tick_at > 0 injects an extra frame_tick at that cycle
  task automatic run_frame(input int dy, input int tick_at, input string tag);
    int cyc, done_cyc, busy_bad;
    bit got_done;
    @(negedge Clk);
    frame_tick = 1'b1; doodle_y = 10'(dy);
    cyc = 0; done_cyc = -1; busy_bad = 0; got_done = 0;
    while (cyc < 40 && !got_done) begin
      @(negedge Clk);
      cyc++;
      frame_tick = (cyc == tick_at);
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin got_done = 1; done_cyc = cyc; end
    end
    frame_tick = 1'b0;
    model_frame(dy);
    if (tick_at > 0) m_overrun = 1;
    check({tag, "_done_cyc"}, 32'(done_cyc), (m_amt == 0) ? 32'd2 : 32'(NP + 2));
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    @(negedge Clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_amt"}, 32'(scroll_amt), 32'(m_amt));
    check({tag, "_overrun"}, {31'd0, overrun}, 32'(m_overrun));
    check({tag, "_score"}, 32'(score), 32'(m_score));
  endtask

  initial begin
    int dy;
    model_reset();
    repeat (2) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    rd_idx = 4'd3; #1;
    check("rst_y3", 32'(rd_y), 32'd180);
    check("rst_x3", 32'(rd_x), 32'd219);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_amt", 32'(scroll_amt), 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check_table("rst");

    run_frame(300, 0, "noscroll");
    check_table("noscroll");

    run_frame(150, 0, "sat");
    rd_idx = 4'd0; #1; check("sat_p0y", 32'(rd_y), 32'd8);
    rd_idx = 4'd7; #1; check("sat_p7y", 32'(rd_y), 32'd428);
`ifdef PLAT_CTRL_SCORE_EN
    check("sat_score8", 32'(score), 32'd8);
`else
    check("sat_score0", 32'(score), 32'd0);
`endif
    check_table("sat");

    for (int f = 2; f <= 8; f++) run_frame(150, 0, $sformatf("f%0d", f));
    rd_idx = 4'd7; #1;
    check("wrap_p7y", 32'(rd_y), 32'd4);
    check("wrap_p7x", 32'(rd_x), 32'd112);
    check_table("wrap");

    check("pre_overrun", {31'd0, overrun}, 32'd0);
    run_frame(150, 4, "ovr");
    check_table("ovr");

    for (int f = 0; f < 24; f++) begin
      dy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(190, 210))
                                       : int'($urandom_range(0, 1023));
      run_frame(dy, 0, $sformatf("rnd%0d", f));
    end
    check_table("rnd");

    // Reset in the middle of a scan
    @(negedge Clk);
    frame_tick = 1'b1; doodle_y = 10'd100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      frame_tick = 1'b0;
      check($sformatf("abort_nodone%0d", c), {31'd0, done}, 32'd0);
    end
    reset = 1'b1; #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    model_reset();
    @(negedge Clk);
    reset = 1'b0;
    check_table("abort");

    for (int f = 0; f < 10; f++) run_frame(int'($urandom_range(0, 199)), 0, $sformatf("post%0d", f));
    check_table("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
